// File: rtl/fruit_spawn_scheduler.sv
// Hanging-fruit slot lifecycle controller with a round-robin grant of the shared random-X source.
// Define FRUIT_FRUIT_FALL_EN to build the FALLING state (eaten fruit drops before cooldown).
module fruit_spawn_scheduler #(
    parameter int NUM_FRUITS     = 5,
    parameter int RESPAWN_FRAMES = 90,
    parameter int Y_BASE         = 160,
    parameter int Y_STEP         = 20,
    parameter int FRUIT_W        = 32,
    parameter int FALL_SPEED     = 4,
    parameter int Y_BOTTOM       = 447
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [NUM_FRUITS-1:0] monkeyCollision,
    input  logic [10:0]           random_X,
    output logic                  rand_req,
    output logic signed [10:0]    topLeftX [NUM_FRUITS],
    output logic signed [10:0]    topLeftY [NUM_FRUITS],
    output logic [NUM_FRUITS-1:0] drawFruit,
    output logic [NUM_FRUITS-1:0] eatenPulse,
    output logic [2:0]            activeCount
);

    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam int PW = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
    localparam logic [10:0] X_MAX = 11'(639 - FRUIT_W);

    if (RESPAWN_FRAMES < 1 || FALL_SPEED < 1 || Y_BOTTOM < Y_BASE) begin : g_param_check
        $error("fruit_spawn_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_EMPTY    = 2'd0,
        S_ACTIVE   = 2'd1,
`ifdef FRUIT_FRUIT_FALL_EN
        S_FALLING  = 2'd3,
`endif
        S_COOLDOWN = 2'd2
    } slot_state_t;

    slot_state_t            state_q [NUM_FRUITS];
    slot_state_t            state_d [NUM_FRUITS];
    logic [CW-1:0]          cnt_q   [NUM_FRUITS];
    logic [CW-1:0]          cnt_d   [NUM_FRUITS];
    logic signed [10:0]     x_d     [NUM_FRUITS];
    logic signed [10:0]     y_d     [NUM_FRUITS];
    logic [NUM_FRUITS-1:0]  draw_d;
    logic [NUM_FRUITS-1:0]  eaten_d;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          ptr_d;
    logic                   req_d;
    logic [2:0]             active_d;
    logic                   grant_valid;
    logic [PW-1:0]          grant_idx;
    logic                   tick;

    assign tick = startOfFrame;

    function automatic logic signed [10:0] base_y(input int i);
        return 11'(Y_BASE + i * Y_STEP);
    endfunction

    // First EMPTY slot at or after the pointer, using pre-edge state only
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_FRUITS; k++) begin
            if (!grant_valid && state_q[(int'(ptr_q) + k) % NUM_FRUITS] == S_EMPTY) begin
                grant_valid = 1'b1;
                grant_idx   = PW'((int'(ptr_q) + k) % NUM_FRUITS);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = topLeftX;
        y_d      = topLeftY;
        draw_d   = drawFruit;
        eaten_d  = '0;
        req_d    = 1'b0;
        ptr_d    = ptr_q;
        active_d = '0;

        if (tick && grant_valid) begin
            req_d = 1'b1;
            ptr_d = (int'(grant_idx) == NUM_FRUITS - 1) ? '0 : grant_idx + 1'b1;
        end

        for (int i = 0; i < NUM_FRUITS; i++) begin
            case (state_q[i])
                S_EMPTY: begin
                    if (tick && grant_valid && int'(grant_idx) == i) begin
                        state_d[i] = S_ACTIVE;
                        x_d[i]     = (random_X > X_MAX) ? X_MAX : random_X;
                        draw_d[i]  = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    // Collision acts on any edge and pre-empts the frame tick
                    if (monkeyCollision[i]) begin
                        eaten_d[i] = 1'b1;
`ifdef FRUIT_FRUIT_FALL_EN
                        state_d[i] = S_FALLING;
`else
                        state_d[i] = S_COOLDOWN;
                        cnt_d[i]   = CW'(RESPAWN_FRAMES);
                        draw_d[i]  = 1'b0;
`endif
                    end
                end
`ifdef FRUIT_FRUIT_FALL_EN
                S_FALLING: begin
                    if (tick) begin
                        if (int'(topLeftY[i]) + FALL_SPEED > Y_BOTTOM) begin
                            state_d[i] = S_COOLDOWN;
                            cnt_d[i]   = CW'(RESPAWN_FRAMES);
                            draw_d[i]  = 1'b0;
                            y_d[i]     = base_y(i);
                        end else begin
                            y_d[i] = topLeftY[i] + 11'(FALL_SPEED);
                        end
                    end
                end
`endif
                S_COOLDOWN: begin
                    if (tick) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (cnt_q[i] == CW'(1)) state_d[i] = S_EMPTY;
                    end
                end
                default: state_d[i] = S_EMPTY;
            endcase
            if (state_d[i] == S_ACTIVE) active_d = active_d + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_FRUITS; i++) begin
                state_q[i]  <= S_EMPTY;
                cnt_q[i]    <= '0;
                topLeftX[i] <= '0;
                topLeftY[i] <= base_y(i);
            end
            ptr_q       <= '0;
            drawFruit   <= '0;
            eatenPulse  <= '0;
            rand_req    <= 1'b0;
            activeCount <= '0;
        end else begin
            for (int i = 0; i < NUM_FRUITS; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                topLeftX[i] <= x_d[i];
                topLeftY[i] <= y_d[i];
            end
            ptr_q       <= ptr_d;
            drawFruit   <= draw_d;
            eatenPulse  <= eaten_d;
            rand_req    <= req_d;
            activeCount <= active_d;
        end
    end

endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed bench for fruit_spawn_scheduler (RESPAWN_FRAMES=3); FALLING checks build under FRUIT_FRUIT_FALL_EN.
module tb_fruit_spawn_scheduler;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic [4:0]         monkeyCollision;
    logic [10:0]        random_X;
    logic               rand_req;
    logic signed [10:0] topLeftX [5];
    logic signed [10:0] topLeftY [5];
    logic [4:0]         drawFruit;
    logic [4:0]         eatenPulse;
    logic [2:0]         activeCount;

    int checks = 0;
    int errors = 0;
    int pulses;

    fruit_spawn_scheduler #(.RESPAWN_FRAMES(3)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .monkeyCollision(monkeyCollision), .random_X(random_X), .rand_req(rand_req),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .drawFruit(drawFruit),
        .eatenPulse(eatenPulse), .activeCount(activeCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: one clock edge with the given startOfFrame, returns at the next negedge
    task automatic step(input logic sof);
        startOfFrame = sof;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_draw"}, int'(drawFruit), 0);
        check({tag, "_eaten"}, int'(eatenPulse), 0);
        check({tag, "_req"}, int'(rand_req), 0);
        check({tag, "_active"}, int'(activeCount), 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_x%0d", tag, i), int'(topLeftX[i]), 0);
            check($sformatf("%s_y%0d", tag, i), int'(topLeftY[i]), 160 + 20 * i);
        end
    endtask

    initial begin
        resetN          = 1'b0;
        startOfFrame    = 1'b0;
        monkeyCollision = '0;
        random_X        = 11'd100;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        resetN = 1'b1;
        step(1'b0);

        // Fill slots 0..4 in order
        for (int k = 1; k <= 5; k++) begin
            step(1'b1);
            check($sformatf("fill%0d_draw", k), int'(drawFruit), (1 << k) - 1);
            check($sformatf("fill%0d_req", k), int'(rand_req), 1);
            check($sformatf("fill%0d_x", k), int'(topLeftX[k-1]), 100);
            check($sformatf("fill%0d_active", k), int'(activeCount), k);
            step(1'b0);
            check($sformatf("fill%0d_req_off", k), int'(rand_req), 0);
        end
        for (int i = 0; i < 5; i++)
            check($sformatf("fill_y%0d", i), int'(topLeftY[i]), 160 + 20 * i);
        step(1'b1);
        check("full_no_grant", int'(rand_req), 0);
        check("full_active", int'(activeCount), 5);

        // Slot 2 collision held for 10 clocks
        monkeyCollision = 5'b00100;
        pulses = 0;
        repeat (10) begin
            step(1'b0);
            pulses += int'(eatenPulse[2]);
        end
        monkeyCollision = '0;
        check("held_pulses", pulses, 1);
        check("held_draw", int'(drawFruit), 5'b11011);
        check("held_active", int'(activeCount), 4);
        for (int t = 1; t <= 3; t++) begin
            step(1'b1);
            check($sformatf("cool2_t%0d_req", t), int'(rand_req), 0);
        end
        random_X = 11'd700;
        step(1'b1);
        check("regrant2_req", int'(rand_req), 1);
        check("regrant2_draw", int'(drawFruit), 5'b11111);
        check("regrant2_clamp", int'(topLeftX[2]), 607);

        // Slot 1 collision on the same edge as a tick
        monkeyCollision = 5'b00010;
        random_X = 11'd150;
        step(1'b1);
        monkeyCollision = '0;
        check("coinc_eaten", int'(eatenPulse), 5'b00010);
        check("coinc_draw", int'(drawFruit), 5'b11101);
        check("coinc_req", int'(rand_req), 0);
        for (int t = 1; t <= 3; t++) begin
            step(1'b1);
            check($sformatf("cool1_t%0d_req", t), int'(rand_req), 0);
        end
        step(1'b1);
        check("regrant1_req", int'(rand_req), 1);
        check("regrant1_x", int'(topLeftX[1]), 150);

        // Cycle slot 0 so the pointer lands on 1
        monkeyCollision = 5'b00001;
        step(1'b0);
        monkeyCollision = '0;
        repeat (4) step(1'b1);
        check("regrant0_draw", int'(drawFruit), 5'b11111);

        // Slots 0 and 3 empty with pointer 1
        monkeyCollision = 5'b01001;
        step(1'b0);
        monkeyCollision = '0;
        check("rr_eaten", int'(eatenPulse), 5'b01001);
        check("rr_active", int'(activeCount), 3);
        repeat (3) step(1'b1);
        check("rr_empty_draw", int'(drawFruit), 5'b10110);
        random_X = 11'd200;
        step(1'b1);
        check("rr_first_draw", int'(drawFruit), 5'b11110);
        check("rr_first_x3", int'(topLeftX[3]), 200);
        random_X = 11'd300;
        step(1'b1);
        check("rr_second_draw", int'(drawFruit), 5'b11111);
        check("rr_second_x0", int'(topLeftX[0]), 300);

`ifdef FRUIT_FRUIT_FALL_EN
        monkeyCollision = 5'b00001;
        step(1'b0);
        monkeyCollision = '0;
        check("fall_eaten", int'(eatenPulse), 5'b00001);
        check("fall_draw", int'(drawFruit), 5'b11111);
        check("fall_active", int'(activeCount), 4);
        for (int k = 1; k <= 71; k++) begin
            step(1'b1);
            check($sformatf("fall_y_t%0d", k), int'(topLeftY[0]), 160 + 4 * k);
            check($sformatf("fall_draw_t%0d", k), int'(drawFruit[0]), 1);
        end
        step(1'b1);
        check("fall_end_y", int'(topLeftY[0]), 160);
        check("fall_end_draw", int'(drawFruit[0]), 0);
        monkeyCollision = 5'b00010;
        step(1'b0);
        monkeyCollision = '0;
        repeat (5) step(1'b1);
        check("midfall_y1", int'(topLeftY[1]), 200);
`else
        monkeyCollision = 5'b10000;
        step(1'b0);
        monkeyCollision = '0;
        step(1'b1);
        check("midop_draw", int'(drawFruit), 5'b01111);
`endif

        // Asynchronous reset mid-operation
        #2 resetN = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        resetN = 1'b1;
        random_X = 11'd50;
        step(1'b1);
        check("post_rst_draw", int'(drawFruit), 5'b00001);
        check("post_rst_x0", int'(topLeftX[0]), 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
